mdu_ctrl: RTL
=============

# mdu_ctrl

Iterative RV32M multiply/divide sequencer in the EX stage, alongside the main ALU. Accepts one M-extension op, runs a 32-step shift-add or shift-subtract sequence, and stalls the pipeline until the result is ready. Handles the RISC-V division special cases in a single cycle. Drives the hazard unit's stall input and the EX-result mux.

## Interface
- `XLEN`, 32, operand and result width; only 32 is supported.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous and active-high.
- `start_i`  in  1  EX holds a valid M op (opcode OP, funct7 = 0000001).
- `funct3_i`  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `flush_i`  in  1  EX-stage flush (branch/jump redirect).
- `operand_a_i`  in  XLEN  rs1 after forwarding.
- `operand_b_i`  in  XLEN  rs2 after forwarding.
- `stall_o`  out  1  freeze IF/ID/EX; ID/EX must hold the instruction.
- `busy_o`  out  1  FSM not in IDLE.
- `valid_o`  out  1  `result_o` valid this cycle; EX may advance.
- `result_o`  out  XLEN  M-op result.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On `start_i && !flush_i`: latch funct3 and operands, and capture sign flags.
  - Convert signed operands to magnitudes:
    - DIV/REM: both operands.
    - MULH: both operands.
    - MULHSU: a only.
  - Clear the step counter (6 bits).
  - Go to CALC, except in the special cases below.
- Special cases go IDLE→DONE directly and skip CALC:
  - b = 0, any div/rem: quotient = all ones; remainder = a.
  - DIV/REM with a = 0x80000000 and b = 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- CALC, multiply:
  - 2·XLEN product register.
  - Each cycle: if multiplier LSB is 1, add multiplicand to the upper half; then shift right 1 with carry-in.
- CALC, divide:
  - Restoring divide with an XLEN+1-bit partial remainder.
  - Each cycle: shift in the next dividend bit, trial-subtract the divisor, set the quotient bit when the result is non-negative.
- CALC exits to DONE after counter = 31, i.e. exactly 32 CALC cycles.
- DONE:
  - Final sign correction is combinational from registered state.
  - Product is negated if signs differ (MULH, MULHSU).
  - Quotient is negated if signs differ; remainder takes the dividend's sign.
  - Output selection: MUL → product[31:0]; MULH* → product[63:32]; DIV* → quotient; REM* → remainder.
  - `valid_o` = 1 for exactly one cycle, then unconditionally return to IDLE.
- `stall_o` = `start_i && state != DONE && !flush_i && !rst_i`. It is asserted in the acceptance cycle and through CALC, and low in DONE.
- A new op can be accepted in the cycle after DONE, with no idle gap.
- `start_i` falling during CALC (not through flush) is illegal; the bench asserts against it.
- Flush has priority over start in every state: next state is IDLE, no `valid_o`, and no result is written.

## Timing
- Reset (any state, including mid-CALC): next state IDLE, all datapath registers zero, counter zero.
  - `result_o` = 0, `valid_o` = 0, `busy_o` = 0, `stall_o` = 0.
- Normal op accepted at cycle 0:
  - CALC occupies cycles 1–32.
  - `valid_o` at cycle 33.
  - `stall_o` high in cycles 0–32.
- Special-case op accepted at cycle 0: DONE at cycle 1 and `valid_o` at cycle 1; `stall_o` high only in cycle 0.
- `busy_o` is high in CALC and DONE.
- `result_o` is 0 whenever `valid_o` = 0.
- A flush in the same cycle as DONE suppresses `valid_o` and `result_o`; state goes to IDLE.

## Structure
- Package `mdu_pkg` holds:
  - `mdu_state_e` (IDLE/CALC/DONE).
  - funct3 localparams: `MDU_MUL` … `MDU_REMU`.
  - `MDU_STEPS` = 32.
- Sub-module `mdu_datapath`:
  - Owns the product, partial-remainder and quotient registers, the adder/subtractor and the sign-correction logic.
  - Controlled by `load`, `step` and `is_div`.
- `mdu_ctrl` owns the FSM, the counter, the special-case detection, the stall/valid logic, and instantiates `mdu_datapath`.

## Test plan
- MUL 7 × 0xFFFFFFFD at cycle 0 → `result_o` = 0xFFFFFFEB with `valid_o` at cycle 33; `stall_o` high cycles 0–32; `busy_o` high cycles 1–33.
- MULHU/MULH/MULHSU with a = b = 0xFFFFFFFF → 0xFFFFFFFE / 0x00000000 / 0xFFFFFFFF.
- DIV, REM, DIVU with a = 0xFFFFFFF9 (−7), b = 2 → DIV 0xFFFFFFFD, REM 0xFFFFFFFF, DIVU 0x7FFFFFFC; each at cycle 33.
- Special cases, each with `valid_o` at cycle 1:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Flush and back-to-back:
  - `flush_i` at cycle 10 of DIV → IDLE at 11, no `valid_o`.
  - New MUL 3×4 started at 11 → 12 at cycle 44.
  - A second op started the cycle after DONE is accepted with no gap.
- `rst_i` during CALC cycle 20 → all outputs 0 next cycle, state IDLE; a subsequent op completes correctly.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared FSM state type, RV32M funct3 encodings and step count for the multiply/divide unit
package mdu_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state_e;
  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;
  localparam int MDU_STEPS = 32;
endpackage

// File: rtl/mdu_datapath.sv
// mdu_datapath: shift-add multiplier / restoring divider with sign correction (load/step/is_div control in, result out)
module mdu_datapath
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic            special,
  input  logic [2:0]      funct3,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);
  logic [2*XLEN-1:0] prod, prod_c;
  logic [XLEN:0]     rem, sum;
  logic [XLEN+1:0]   sh, diff;
  logic [XLEN-1:0]   quo, dvs, am, bm, quo_c, rem_c;
  logic              neg_q, neg_r, a_neg, b_neg, sa, sb;
  assign sa    = funct3 inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  assign sb    = funct3 inside {MDU_MULH, MDU_DIV, MDU_REM};
  assign a_neg = sa && a[XLEN-1];
  assign b_neg = sb && b[XLEN-1];
  assign am    = a_neg ? -a : a;
  assign bm    = b_neg ? -b : b;
  assign sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, dvs} : '0);
  assign sh    = {rem, quo[XLEN-1]};
  assign diff  = sh - {2'b0, dvs};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod  <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (load) begin
      prod  <= {{XLEN{1'b0}}, am};
      quo   <= !special ? am : b == '0 ? '1 : {1'b1, {(XLEN-1){1'b0}}};
      rem   <= (!special || b != '0) ? '0 : {1'b0, a};
      dvs   <= bm;
      neg_q <= !special && (a_neg ^ b_neg);
      neg_r <= !special && a_neg;
    end else if (step && is_div) begin
      quo <= {quo[XLEN-2:0], !diff[XLEN+1]};
      rem <= diff[XLEN+1] ? sh[XLEN:0] : diff[XLEN:0];
    end else if (step) begin
      prod <= {sum, prod[XLEN-1:1]};
    end
  end
  assign prod_c = neg_q ? -prod : prod;
  assign quo_c  = neg_q ? -quo : quo;
  assign rem_c  = neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
  assign result = op == MDU_MUL ? prod_c[XLEN-1:0] :
                  !op[2]        ? prod_c[2*XLEN-1:XLEN] :
                  !op[1]        ? quo_c : rem_c;
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: RV32M sequencer (start/funct3/flush/operands in; stall/busy/valid/result out) with IDLE/CALC/DONE FSM
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);
  mdu_state_e      state;
  logic [5:0]      cnt;
  logic [2:0]      op_q;
  logic            special, load;
  logic [XLEN-1:0] res;
  assign special = funct3_i[2] && (operand_b_i == '0 ||
                   (!funct3_i[0] && operand_a_i == {1'b1, {(XLEN-1){1'b0}}} && operand_b_i == '1));
  assign load    = state == IDLE && start_i && !flush_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state <= special ? DONE : CALC;
          cnt   <= '0;
          op_q  <= funct3_i;
        end
        CALC: begin
          cnt   <= cnt + 6'd1;
          state <= cnt == 6'(MDU_STEPS - 1) ? DONE : CALC;
        end
        default: state <= IDLE;
      endcase
    end
  end
  mdu_datapath #(.XLEN(XLEN)) u_dp (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (load),
    .step    (state == CALC),
    .is_div  (op_q[2]),
    .special (special),
    .funct3  (funct3_i),
    .op      (op_q),
    .a       (operand_a_i),
    .b       (operand_b_i),
    .result  (res)
  );
  assign stall_o  = start_i && state != DONE && !flush_i && !rst_i;
  assign busy_o   = state != IDLE;
  assign valid_o  = state == DONE && !flush_i;
  assign result_o = valid_o ? res : '0;
endmodule
